// File: rtl/capp_cmd_initiator_if.sv
// Request, byte-stream and response handshake bundle for the CAPP command initiator.
// The initiator takes the slave view; whatever drives it (host, sequencer, bench) takes the master view.
interface capp_cmd_initiator_if;
    logic [3:0]  req_op;
    logic [31:0] req_data;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_valid;
    logic        rsp_ready;

    modport slave (
        input  req_op, req_data, req_valid, tx_ready, rx_data, rx_valid, rsp_ready,
        output req_ready, tx_data, tx_valid, rx_ready, rsp_data, rsp_err, rsp_valid
    );

    modport master (
        output req_op, req_data, req_valid, tx_ready, rx_data, rx_valid, rsp_ready,
        input  req_ready, tx_data, tx_valid, rx_ready, rsp_data, rsp_err, rsp_valid
    );
endinterface

// File: rtl/capp_cmd_initiator.sv
// Host-side CAPP initiator: serialises one CAM op into command/data bytes and
// assembles the interpreter's reply bytes into a 32-bit response word.
module capp_cmd_initiator #(
    parameter int NUM_BYTES      = 4,
    parameter int TAG_BYTES      = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    capp_cmd_initiator_if.slave  bus
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_DATA = 3'd2,
        RECV_RSP  = 3'd3,
        GAP       = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t             state_r;
    logic [3:0]         op_r;
    logic [31:0]        data_r;
    logic [2:0]         tx_idx_r;
    logic [2:0]         rx_idx_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               req_ready_r;
    logic               tx_valid_r;
    logic [7:0]         tx_data_r;
    logic               rx_ready_r;
    logic [31:0]        rsp_data_r;
    logic               rsp_err_r;
    logic               rsp_valid_r;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd10);
    endfunction

    function automatic logic op_has_data(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd2);
    endfunction

    function automatic logic op_has_reply(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd3) || (op == 4'd5) || (op == 4'd9);
    endfunction

    // get-tags returns the short tag vector; every other reply is a full CAM word
    function automatic logic [2:0] reply_len(input logic [3:0] op);
        return (op == 4'd5) ? 3'(TAG_BYTES) : 3'(NUM_BYTES);
    endfunction

    // Op sequencer: one op in flight, every output driven from a register
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            op_r        <= 4'd0;
            data_r      <= 32'd0;
            tx_idx_r    <= 3'd0;
            rx_idx_r    <= 3'd0;
            gap_cnt_r   <= '0;
            tmo_cnt_r   <= '0;
            req_ready_r <= 1'b1;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'd0;
            rx_ready_r  <= 1'b1;
            rsp_data_r  <= 32'd0;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_r        <= bus.req_op;
                        data_r      <= bus.req_data;
                        req_ready_r <= 1'b0;
                        rsp_data_r  <= 32'd0;
                        tx_idx_r    <= 3'd0;
                        rx_idx_r    <= 3'd0;
                        gap_cnt_r   <= '0;
                        tmo_cnt_r   <= '0;
                        if (op_legal(bus.req_op)) begin
                            tx_valid_r <= 1'b1;
                            tx_data_r  <= 8'h61 + {4'h0, bus.req_op};
                            state_r    <= SEND_CMD;
                        end else begin
                            rsp_err_r   <= 1'b1;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end
                    end
                end
                SEND_CMD: begin
                    if (bus.tx_ready) begin
                        if (op_has_data(op_r)) begin
                            tx_data_r <= data_r[7:0];
                            data_r    <= {8'h00, data_r[31:8]};
                            tx_idx_r  <= 3'd1;
                            state_r   <= SEND_DATA;
                        end else begin
                            tx_valid_r <= 1'b0;
                            state_r    <= op_has_reply(op_r) ? RECV_RSP : GAP;
                        end
                    end
                end
                SEND_DATA: begin
                    // tx_idx_r counts the payload byte currently on tx_data
                    if (bus.tx_ready) begin
                        if (tx_idx_r == 3'(NUM_BYTES)) begin
                            tx_valid_r <= 1'b0;
                            state_r    <= GAP;
                        end else begin
                            tx_data_r <= data_r[7:0];
                            data_r    <= {8'h00, data_r[31:8]};
                            tx_idx_r  <= tx_idx_r + 3'd1;
                        end
                    end
                end
                RECV_RSP: begin
                    if (bus.rx_valid) begin
                        rsp_data_r <= {rsp_data_r[23:0], bus.rx_data};
                        tmo_cnt_r  <= '0;
                        if (rx_idx_r == reply_len(op_r) - 3'd1) begin
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 3'd1;
                        end
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // partial reply is kept so the host can see how far it got
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                        rsp_data_r  <= 32'd0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    tx_valid_r  <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    // rx is always consumed; bytes outside RECV_RSP are simply dropped
    assign bus.req_ready = req_ready_r;
    assign bus.tx_valid  = tx_valid_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.rx_ready  = rx_ready_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_valid = rsp_valid_r;
endmodule

// File: tb/tb_capp_cmd_initiator.sv
// Scoreboard bench for capp_cmd_initiator: expected tx bytes and responses are queued
// when a request is issued and checked as the DUT hands them over.
module tb_capp_cmd_initiator;
    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0]  exp_tx[$];
    logic [32:0] exp_rsp[$];

    capp_cmd_initiator_if bus();

    capp_cmd_initiator dut (
        .clk_48mhz (clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes complete on the next rising edge; sampled mid-cycle here
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", {56'd0, bus.tx_data}, 64'hFFFF);
                else chk("tx_byte", {56'd0, bus.tx_data}, {56'd0, exp_tx.pop_front()});
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", {31'd0, bus.rsp_err, bus.rsp_data}, 64'hFFFF_FFFF_FFFF);
                else chk("rsp_word", {31'd0, bus.rsp_err, bus.rsp_data}, {31'd0, exp_rsp.pop_front()});
            end
        end
    end

    task automatic do_req(input logic [3:0] op, input logic [31:0] d);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready", {63'd0, bus.req_ready}, 64'd1);
        bus.req_op    = op;
        bus.req_data  = d;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Waits for the command byte to go out, then returns the low n bytes of w, MSB first
    task automatic send_rx(input logic [31:0] w, input int n);
        int k = 0;
        while (exp_tx.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("cmd_sent", {63'd0, exp_tx.size() == 0}, 64'd1);
        for (int i = n - 1; i >= 0; i--) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = w[8*i +: 8];
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_rsp.size() != 0) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {63'd0, exp_tx.size() == 0 && exp_rsp.size() == 0}, 64'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tx_valid"},  {63'd0, bus.tx_valid},  64'd0);
        chk({tag, "_tx_data"},   {56'd0, bus.tx_data},   64'd0);
        chk({tag, "_rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
        chk({tag, "_rsp_err"},   {63'd0, bus.rsp_err},   64'd0);
        chk({tag, "_rsp_data"},  {32'd0, bus.rsp_data},  64'd0);
        chk({tag, "_rx_ready"},  {63'd0, bus.rx_ready},  64'd1);
        chk({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        int n;
        reset_n       = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_data  = 32'd0;
        bus.req_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.rx_data   = 8'd0;
        bus.rx_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 'a' with payload: command then LSB-first data, no reply
        exp_tx = '{8'h61, 8'h44, 8'h33, 8'h22, 8'h11};
        exp_rsp.push_back({1'b0, 32'h0});
        do_req(4'd0, 32'h11223344);
        wait_done("op_a_done", 500);

        // stray reply byte in IDLE is drained, then 'b' read
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        @(negedge clk);
        chk("drain_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        exp_tx.push_back(8'h62);
        exp_rsp.push_back({1'b0, 32'hDEADBEEF});
        do_req(4'd1, 32'hFFFF_FFFF);
        send_rx(32'hDEADBEEF, 4);
        wait_done("op_b_done", 200);

        // 'f' get-tags: two-byte reply, zero-extended
        exp_tx.push_back(8'h66);
        exp_rsp.push_back({1'b0, 32'h00008001});
        do_req(4'd5, 32'd0);
        send_rx(32'h00008001, 2);
        wait_done("op_f_done", 200);

        // illegal op: error response, no bytes; then 'e' back to back
        exp_rsp.push_back({1'b1, 32'h0});
        do_req(4'd12, 32'h12345678);
        wait_done("op_illegal_done", 100);
        exp_tx.push_back(8'h65);
        exp_rsp.push_back({1'b0, 32'h0});
        do_req(4'd4, 32'd0);
        wait_done("op_e_done", 200);

        // 'c' with tx_ready low for 7 cycles while the third byte is presented
        exp_tx = '{8'h63, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        exp_rsp.push_back({1'b0, 32'h0});
        do_req(4'd2, 32'hA1B2C3D4);
        n = 0;
        while (exp_tx.size() > 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("stall_tx_valid", {63'd0, bus.tx_valid}, 64'd1);
            chk("stall_tx_data",  {56'd0, bus.tx_data},  64'hC3);
        end
        @(posedge clk); #1;
        bus.tx_ready = 1'b1;
        wait_done("op_c_done", 300);

        // reset pulsed in the middle of a 'd' read drops the op
        exp_tx.push_back(8'h64);
        do_req(4'd3, 32'd0);
        send_rx(32'h000000AB, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        chk_idle_outputs("midop_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midop_queues", {32'd0, exp_tx.size() + exp_rsp.size()}, 64'd0);
        exp_tx.push_back(8'h62);
        exp_rsp.push_back({1'b0, 32'h01020304});
        do_req(4'd1, 32'd0);
        send_rx(32'h01020304, 4);
        wait_done("post_reset_done", 200);

        // 'j' read that stalls after two bytes: timeout keeps the partial word
        exp_tx.push_back(8'h6A);
        exp_rsp.push_back({1'b1, 32'h00001234});
        do_req(4'd9, 32'd0);
        send_rx(32'h00001234, 2);
        n = 0;
        while (n < 70000) begin
            @(posedge clk); #1;
            n++;
            if (bus.rsp_valid) break;
        end
        chk("timeout_window", {63'd0, (n >= 65534) && (n <= 65536)}, 64'd1);
        wait_done("op_j_done", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
